// File: rtl/serial_subtractor_8bit.sv
// rtl/serial_subtractor_8bit.sv - bit-serial 8-bit subtractor, LSB first, IDLE/RUN/DONE control
module serial_subtractor_8bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic [7:0] diff,
  output logic       bout,
  output logic       ovf,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [7:0] a_sr;
  logic [7:0] b_sr;
  logic [7:0] res_sr;
  logic       br;
  logic [2:0] cnt;
  logic       a_msb;
  logic       b_msb;

  logic       a0;
  logic       b0;
  logic       d_bit;
  logic       br_next;

  always_comb begin
    a0      = a_sr[0];
    b0      = b_sr[0];
    d_bit   = a0 ^ b0 ^ br;
    br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= 8'h00;
      b_sr   <= 8'h00;
      res_sr <= 8'h00;
      br     <= 1'b0;
      cnt    <= 3'd0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= 8'h00;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= in_a;
            b_sr  <= in_b;
            a_msb <= in_a[7];
            b_msb <= in_b[7];
            br    <= 1'b0;
            cnt   <= 3'd0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d_bit, res_sr[7:1]};
          br     <= br_next;
          cnt    <= cnt + 3'd1;
          // Bit 7 is in flight: publish the full result on this same edge.
          if (cnt == 3'd7) begin
            diff  <= {d_bit, res_sr[7:1]};
            bout  <= br_next;
            ovf   <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// tb/tb_serial_subtractor_8bit.sv - self-checking bench for serial_subtractor_8bit
module tb_serial_subtractor_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  serial_subtractor_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in_a  (in_a),
    .in_b  (in_b),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: integer subtraction, borrow from the sign of the unsigned difference,
  // overflow from the signed difference leaving the 8-bit range.
  function automatic void ref_sub(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] d, output logic bo, output logic ov);
    int ur;
    int sr;
    ur = int'(a) - int'(b);
    sr = int'({{24{a[7]}}, a}) - int'({{24{b[7]}}, b});
    d  = ur[7:0];
    bo = (ur < 0);
    ov = (sr < -128) || (sr > 127);
  endfunction

  // One operation with a one-cycle start; checks the busy window, done pulse and result.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] e_diff, input logic e_bout, input logic e_ovf,
                       input string tag);
    int busy_ok;
    @(negedge clk);
    start = 1'b1;
    in_a  = a;
    in_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_a  = 8'($urandom);
    in_b  = 8'($urandom);
    busy_ok = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy && !done) busy_ok++;
      if (i == 3) begin
        in_a = 8'($urandom);
        in_b = 8'($urandom);
      end
    end
    chk({tag, "_busy_cycles"}, busy_ok, 8);
    @(negedge clk);
    chk({tag, "_done"}, {busy, done}, 2'b01);
    chk({tag, "_diff"}, diff, e_diff);
    chk({tag, "_bout"}, bout, e_bout);
    chk({tag, "_ovf"}, ovf, e_ovf);
    @(negedge clk);
    chk({tag, "_done_drop"}, {busy, done}, 2'b00);
  endtask

  vec_t vecs[$];

  initial begin
    logic [7:0] ra, rb, rd;
    logic       rbo, rov;
    int         pulses;
    int         pulse_at[$];
    int         unstable;

    vecs.push_back('{8'h05, 8'h03, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1});
    vecs.push_back('{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1});
    vecs.push_back('{8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0});
    vecs.push_back('{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0});

    rst_n = 1'b0;
    start = 1'b1;
    in_a  = 8'hAA;
    in_b  = 8'h55;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {diff, bout, ovf, busy, done}, 12'h000);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("reset_idle", {busy, done}, 2'b00);

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout, vecs[i].ovf, $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = (i % 7 == 0) ? ra : 8'($urandom);
      ref_sub(ra, rb, rd, rbo, rov);
      do_op(ra, rb, rd, rbo, rov, $sformatf("rnd%0d", i));
    end

    // A second start three cycles into RUN must be ignored.
    @(negedge clk);
    start = 1'b1;
    in_a  = 8'h20;
    in_b  = 8'h0C;
    @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) pulses++;
      if (i == 2) begin
        start = 1'b1;
        in_a  = 8'hFF;
        in_b  = 8'h01;
      end else begin
        start = 1'b0;
      end
    end
    chk("ignore_start_pulses", pulses, 1);
    chk("ignore_start_diff", {diff, bout, ovf}, {8'h14, 2'b00});

    // Reset four cycles into RUN aborts the operation.
    @(negedge clk);
    start = 1'b1;
    in_a  = 8'h33;
    in_b  = 8'h11;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {diff, bout, ovf, busy, done}, 12'h000);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    do_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, "after_abort");

    // start held high for 30 cycles: one operation every 10 cycles.
    @(negedge clk);
    start = 1'b1;
    in_a  = 8'h09;
    in_b  = 8'h04;
    unstable = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulse_at.push_back(i);
        if (diff !== 8'h05) unstable++;
      end else if (pulse_at.size() > 0 && diff !== 8'h05) begin
        unstable++;
      end
      if (i == 30) start = 1'b0;
    end
    repeat (12) begin
      @(negedge clk);
      if (done) pulse_at.push_back(-1);
    end
    chk("b2b_pulses", pulse_at.size(), 3);
    if (pulse_at.size() == 3) begin
      chk("b2b_gap1", pulse_at[1] - pulse_at[0], 10);
      chk("b2b_gap2", pulse_at[2] - pulse_at[1], 10);
    end
    chk("b2b_diff_stable", unstable, 0);
    chk("b2b_final", {diff, bout, ovf, busy, done}, {8'h05, 4'b0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
